// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and sizing constants for the pong controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int WIDTH_DEF  = 20;
  localparam int HEIGHT_DEF = 10;
  localparam int SCORE_W    = 4;

endpackage

// File: rtl/pong_frame_divider.sv
// pong_frame_divider: counts frame pulses and flags the pulse that completes a period.
// Latency: tc is combinational on the completing frame pulse; the count restarts at 0.
// Backpressure: none; frames seen while clear is high are dropped.
// Ports: clock/reset (async active-low), frame pulse, clear (hold count at 0),
//        load (period in frames, >= 1), tc (terminal-count strobe).
module pong_frame_divider #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame,
  input  logic             clear,
  input  logic [CNT_W-1:0] load,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (frame) begin
      // The load-th pulse of a period is the terminal one.
      if (cnt_q == load - 1'b1) begin
        tc    = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_game_controller.sv
// pong_game_controller: IDLE/SERVE/PLAY/POINT/OVER sequencer, move/serve strobes, scoring.
// Latency: all outputs registered; move/serve appear one cycle after the deciding edge.
// Backpressure: none; frame pulses outside SERVE/PLAY (incl. the POINT cycle) are ignored.
// Ports: clock, reset (async active-low), frame pulse, start level, ball edges
//        top/bottom/left/right (signed), paddle_l/paddle_r top rows;
//        outputs move, serve, score_l, score_r, state, winner.
// Optional: define PONG_SPEEDUP_EN to shorten the move period by one frame every
//        4th paddle hit (floor 1), restored to FRAMES_PER_MOVE on each serve.
module pong_game_controller import pong_pkg::*; #(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int HEIGHT          = HEIGHT_DEF,
  parameter int XBITS           = $clog2(WIDTH),
  parameter int YBITS           = $clog2(HEIGHT),
  parameter int FRAMES_PER_MOVE = 2,
  parameter int PADDLE_HEIGHT   = 3,
  parameter int WIN_SCORE       = 5,
  parameter int SERVE_DELAY     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame,
  input  logic                start,
  input  logic signed [YBITS:0] top,
  input  logic signed [YBITS:0] bottom,
  input  logic signed [XBITS:0] left,
  input  logic signed [XBITS:0] right,
  input  logic [YBITS-1:0]    paddle_l,
  input  logic [YBITS-1:0]    paddle_r,
  output logic                move,
  output logic                serve,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic [2:0]          state,
  output logic                winner
);

  // Divider width must hold SERVE_DELAY and the largest move period.
  localparam int CNT_W = 8;
  localparam logic [3:0]           FPM_INIT   = 4'(FRAMES_PER_MOVE);
  localparam logic [SCORE_W-1:0]   WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic signed [XBITS:0] LEFT_WALL  = '0;
  localparam logic signed [XBITS:0] RIGHT_WALL = (XBITS+1)'(WIDTH-1);

  state_t             state_q, state_d;
  logic               move_q, move_d;
  logic               serve_q, serve_d;
  logic               winner_q, winner_d;
  logic               point_r_q, point_r_d;   // 1: last point went to the right player
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [3:0]         rate;

`ifdef PONG_SPEEDUP_EN
  logic [3:0] rate_q, rate_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  assign rate = rate_q;
`else
  assign rate = FPM_INIT;
`endif

  // Frame divider: SERVE delay and PLAY move period share one counter; it is
  // always at 0 when switching between them because tc restarts it.
  logic             div_clear, div_tc;
  logic [CNT_W-1:0] div_load;

  assign div_clear = !((state_q == SERVE) || (state_q == PLAY));
  assign div_load  = (state_q == SERVE) ? CNT_W'(SERVE_DELAY) : CNT_W'(rate);

  pong_frame_divider #(.CNT_W(CNT_W)) u_div (
    .clock (clock),
    .reset (reset),
    .frame (frame),
    .clear (div_clear),
    .load  (div_load),
    .tc    (div_tc)
  );

  // Paddle span computed one bit wider than the row index so it cannot wrap,
  // then compared signed against the ball edges.
  logic signed [YBITS:0] pad_l_top, pad_l_bot, pad_r_top, pad_r_bot;
  logic overlap_l, overlap_r, at_l, at_r, miss_l, miss_r;

  assign pad_l_top = $signed({1'b0, paddle_l});
  assign pad_l_bot = $signed({1'b0, paddle_l} + (YBITS+1)'(PADDLE_HEIGHT-1));
  assign pad_r_top = $signed({1'b0, paddle_r});
  assign pad_r_bot = $signed({1'b0, paddle_r} + (YBITS+1)'(PADDLE_HEIGHT-1));

  assign overlap_l = (bottom >= pad_l_top) && (top <= pad_l_bot);
  assign overlap_r = (bottom >= pad_r_top) && (top <= pad_r_bot);
  assign at_l      = (left <= LEFT_WALL);
  assign at_r      = (right >= RIGHT_WALL);
  assign miss_l    = at_l && !overlap_l;
  assign miss_r    = at_r && !overlap_r;

  always_comb begin
    state_d   = state_q;
    move_d    = 1'b0;
    serve_d   = 1'b0;
    winner_d  = winner_q;
    point_r_d = point_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
`ifdef PONG_SPEEDUP_EN
    rate_d    = rate_q;
    hit_cnt_d = hit_cnt_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = SERVE;
          serve_d   = 1'b1;
        end
      end
      SERVE: begin
        if (div_tc) state_d = PLAY;
      end
      PLAY: begin
        if (div_tc) begin
          // Left miss wins a simultaneous double miss.
          if (miss_l) begin
            score_r_d = score_r_q + 1'b1;
            point_r_d = 1'b1;
            state_d   = POINT;
          end else if (miss_r) begin
            score_l_d = score_l_q + 1'b1;
            point_r_d = 1'b0;
            state_d   = POINT;
          end else begin
            move_d = 1'b1;
`ifdef PONG_SPEEDUP_EN
            if ((at_l && overlap_l) || (at_r && overlap_r)) begin
              hit_cnt_d = hit_cnt_q + 2'd1;
              if ((hit_cnt_q == 2'd3) && (rate_q > 4'd1)) rate_d = rate_q - 4'd1;
            end
`endif
          end
        end
      end
      POINT: begin
        if ((point_r_q ? score_r_q : score_l_q) == WIN_VAL) begin
          state_d  = OVER;
          winner_d = point_r_q;
        end else begin
          state_d = SERVE;
          serve_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PONG_SPEEDUP_EN
    if (serve_d) begin
      rate_d    = FPM_INIT;
      hit_cnt_d = 2'd0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      move_q    <= 1'b0;
      serve_q   <= 1'b0;
      winner_q  <= 1'b0;
      point_r_q <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
`ifdef PONG_SPEEDUP_EN
      rate_q    <= FPM_INIT;
      hit_cnt_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      serve_q   <= serve_d;
      winner_q  <= winner_d;
      point_r_q <= point_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
`ifdef PONG_SPEEDUP_EN
      rate_q    <= rate_d;
      hit_cnt_q <= hit_cnt_d;
`endif
    end
  end

  assign move    = move_q;
  assign serve   = serve_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign state   = state_q;
  assign winner  = winner_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: directed stimulus with a game-rule model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_pong_game_controller;

  localparam int W   = 20;
  localparam int XB  = 5;
  localparam int YB  = 4;
  localparam int SD  = 8;
  localparam int PH  = 3;
  localparam int WIN = 5;
`ifdef PONG_SPEEDUP_EN
  localparam int FPM = 3;
`else
  localparam int FPM = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic frame = 1'b0;
  logic start = 1'b0;
  logic signed [YB:0] top = '0, bottom = '0;
  logic signed [XB:0] left = '0, right = '0;
  logic [YB-1:0] paddle_l = '0, paddle_r = '0;
  logic move, serve, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  pong_game_controller #(.FRAMES_PER_MOVE(FPM)) dut (
    .clock(clock), .reset(reset), .frame(frame), .start(start),
    .top(top), .bottom(bottom), .left(left), .right(right),
    .paddle_l(paddle_l), .paddle_r(paddle_r),
    .move(move), .serve(serve), .score_l(score_l), .score_r(score_r),
    .state(state), .winner(winner)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-rule model: state numbers 0..4 = IDLE, SERVE, PLAY, POINT, OVER.
  int m_state, m_sl, m_sr, m_frames, m_move, m_serve, m_win, m_scorer, m_rate, m_hits;
  int t, b, l, r, pl, pr;
  bit ov_l, ov_r, lm, rm;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_sl = 0; m_sr = 0; m_frames = 0; m_move = 0; m_serve = 0;
      m_win = 0; m_scorer = 0; m_rate = FPM; m_hits = 0;
    end else begin
      m_move = 0;
      m_serve = 0;
      case (m_state)
        0, 4: if (start) begin
          m_sl = 0; m_sr = 0; m_frames = 0; m_state = 1; m_serve = 1;
        end
        1: if (frame) begin
          m_frames++;
          if (m_frames == SD) begin m_frames = 0; m_state = 2; end
        end
        2: if (frame) begin
          m_frames++;
          if (m_frames == m_rate) begin
            m_frames = 0;
            t = $signed(top); b = $signed(bottom); l = $signed(left); r = $signed(right);
            pl = int'(paddle_l); pr = int'(paddle_r);
            ov_l = (b >= pl) && (t <= pl + PH - 1);
            ov_r = (b >= pr) && (t <= pr + PH - 1);
            lm = (l <= 0) && !ov_l;
            rm = (r >= W - 1) && !ov_r;
            if (lm) begin m_sr++; m_scorer = 1; m_state = 3; end
            else if (rm) begin m_sl++; m_scorer = 0; m_state = 3; end
            else begin
              m_move = 1;
`ifdef PONG_SPEEDUP_EN
              if (((l <= 0) && ov_l) || ((r >= W - 1) && ov_r)) begin
                m_hits++;
                if (m_hits % 4 == 0 && m_rate > 1) m_rate--;
              end
`endif
            end
          end
        end
        3: begin
          if ((m_scorer ? m_sr : m_sl) == WIN) begin m_state = 4; m_win = m_scorer; end
          else begin m_state = 1; m_serve = 1; m_frames = 0; end
        end
        default: m_state = 0;
      endcase
      if (m_serve) begin m_rate = FPM; m_hits = 0; end
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("cyc_move", move, m_move);
      chk("cyc_serve", serve, m_serve);
      chk("cyc_score_l", score_l, m_sl);
      chk("cyc_score_r", score_r, m_sr);
      chk("cyc_state", state, m_state);
      chk("cyc_winner", winner, m_win);
    end
  end

  // Pulse counters sample the registered outputs just before each edge.
  int n_move = 0, n_serve = 0;
  always @(posedge clock) begin
    if (move === 1'b1) n_move++;
    if (serve === 1'b1) n_serve++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_frame();
    @(negedge clock); frame = 1'b1;
    @(negedge clock); frame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin pulse_frame(); wait_cyc(2); end
  endtask

  task automatic start_pulse();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic set_ball(input int lc, input int rc, input int tr, input int br);
    left = (XB+1)'(lc); right = (XB+1)'(rc); top = (YB+1)'(tr); bottom = (YB+1)'(br);
  endtask

  task automatic one_point();
    frames(SD);
    repeat (FPM) pulse_frame();
    wait_cyc(2);
  endtask

  int m0, s0;

  initial begin
    set_ball(5, 6, 4, 5);
    paddle_l = 4'd0; paddle_r = 4'd0;
    wait_cyc(2);
    run_cmp = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_score_l", score_l, 0);
    chk("rst_score_r", score_r, 0);
    chk("rst_move", move, 0);
    chk("rst_serve", serve, 0);
    chk("rst_winner", winner, 0);
    @(negedge clock); reset = 1'b1;
    wait_cyc(4);
    chk("idle_hold", state, 0);

    // Open field: one serve, then one move per FPM frames.
    m0 = n_move; s0 = n_serve;
    start_pulse();
    chk("start_serve", serve, 1);
    chk("start_state", state, 1);
    frames(SD);
    chk("play_after_delay", state, 2);
    chk("no_move_in_serve", n_move - m0, 0);
    frames(3 * FPM);
    wait_cyc(1);
    chk("open_moves", n_move - m0, 3);
    chk("one_serve", n_serve - s0, 1);
    chk("open_score_r", score_r, 0);

    // Left paddle hit, then left miss.
    set_ball(0, 1, 2, 3); paddle_l = 4'd1;
    repeat (FPM) pulse_frame();
    chk("hit_move", move, 1);
    chk("hit_score_r", score_r, 0);
    paddle_l = 4'd6;
    repeat (FPM) pulse_frame();
    chk("miss_state_point", state, 3);
    chk("miss_score_r", score_r, 1);
    chk("miss_no_move", move, 0);
    wait_cyc(1);
    chk("miss_state_serve", state, 1);
    chk("miss_serve", serve, 1);

    // Double miss: left has priority.
    set_ball(0, 19, 7, 8); paddle_l = 4'd0; paddle_r = 4'd0;
    frames(SD);
    repeat (FPM) pulse_frame();
    chk("dbl_score_r", score_r, 2);
    chk("dbl_score_l", score_l, 0);
    chk("dbl_state", state, 3);
    wait_cyc(2);

    // Right misses up to score_l=3, then reset mid-PLAY.
    set_ball(10, 19, 7, 8);
    repeat (3) one_point();
    chk("three_score_l", score_l, 3);
    frames(SD);
    pulse_frame();
    chk("pre_rst_state", state, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_score_l", score_l, 0);
    chk("arst_score_r", score_r, 0);
    chk("arst_move", move, 0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(5);
    chk("idle_after_rst", state, 0);

    // Five right misses: left wins.
    m0 = n_move;
    start_pulse();
    chk("restart_serve", serve, 1);
    repeat (5) one_point();
    chk("over_state", state, 4);
    chk("over_score_l", score_l, 5);
    chk("over_score_r", score_r, 0);
    chk("over_winner", winner, 0);
    chk("over_no_move", n_move - m0, 0);
    frames(2);
    chk("over_hold_state", state, 4);
    chk("over_hold_score", score_l, 5);
    start_pulse();
    chk("again_state", state, 1);
    chk("again_serve", serve, 1);
    chk("again_score_l", score_l, 0);

    // Five left misses: right wins.
    set_ball(0, 1, 7, 8); paddle_l = 4'd0;
    repeat (5) one_point();
    chk("rwin_state", state, 4);
    chk("rwin_score_r", score_r, 5);
    chk("rwin_winner", winner, 1);

`ifdef PONG_SPEEDUP_EN
    start_pulse();
    set_ball(0, 1, 2, 3); paddle_l = 4'd1;
    frames(SD);
    repeat (4) repeat (FPM) pulse_frame();
    repeat (2) pulse_frame();
    chk("fast_move", move, 1);
    paddle_l = 4'd6;
    repeat (2) pulse_frame();
    chk("fast_miss_point", state, 3);
    wait_cyc(1);
    chk("fast_miss_serve", serve, 1);
    paddle_l = 4'd1;
    frames(SD);
    repeat (2) pulse_frame();
    chk("rate_restored_early", move, 0);
    pulse_frame();
    chk("rate_restored_move", move, 1);
`endif

    wait_cyc(2);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
